uart_tx_sched: RTL
==================

// Module: uart_tx_sched
// PURPOSE
//   Shares one UART transmitter among NREQ byte producers. Arbitrates round-robin,
//   latches the winner's byte, issues a one-cycle start to the transmitter, tracks
//   its busy flag through the frame, then enforces an inter-frame gap. Sits between
//   the application byte sources and the uart_tx frame/baud datapath.
// PARAMETERS
//   NREQ    4     number of requesters (2..8)
//   GAP     16    idle clk cycles after frame end before next grant (0 = none)
//   ACK_TO  64    clk cycles allowed for tx_busy to rise after tx_start (>=1)
// PORTS
//   clk        in   1        system clock
//   rst        in   1        async reset, active-low
//   req_valid  in   NREQ     requester i has a byte pending
//   req_data   in   NREQ*8   byte of requester i at [8*i+7:8*i]
//   req_ready  out  NREQ     one-hot accept; transfer when valid&ready
//   tx_data    out  8        byte presented to transmitter
//   tx_start   out  1        one-cycle pulse: begin frame with tx_data
//   tx_busy    in   1        transmitter frame in progress
//   grant_id   out  clog2(NREQ) index of requester currently served
//   active     out  1        high in any state other than IDLE
//   err        out  1        one-cycle pulse on ack timeout
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, ptr=NREQ-1, tx_data=0, tx_start=0, grant_id=0,
//     err=0, counters=0; req_ready=0 (all bits). Reset mid-frame abandons the byte.
//   States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
//   IDLE: winner = first i with req_valid[i], scanning ptr+1, ptr+2 .. mod NREQ.
//     req_ready = onehot(winner) combinationally, only in IDLE and only if any valid.
//     On edge with a transfer: tx_data<=req_data[winner], grant_id<=winner,
//     ptr<=winner, -> START. No valid: stay.
//   START: tx_start=1 this cycle only; clear timeout counter; -> WAIT_BUSY.
//   WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Else count; at ACK_TO cycles without busy:
//     err=1 for one cycle, -> IDLE (no gap; byte dropped, ptr still advanced).
//   WAIT_DONE: stay while tx_busy=1; tx_busy=0 -> GAP (GAP=0: -> IDLE).
//   GAP: count GAP cycles then -> IDLE; req_valid ignored meanwhile.
//   Latency: transfer edge -> tx_start high next cycle (1 clk). Earliest next accept:
//     frame end + GAP + 1 clk.
//   tx_data and grant_id hold from transfer until next transfer.
//   req_valid changing while not in IDLE has no effect; requester must hold byte
//     stable while valid and not yet accepted.
//   Counters sized clog2(max(GAP,ACK_TO)+1); no wrap reachable.
//   tx_busy already high in START is ignored; sampled only from WAIT_BUSY on.
//   Fairness: with all valid continuously, grants go 0,1,..,NREQ-1,0,...
// TESTING
//   1. Reset, req_valid=0001, byte 0x41; model busy 3 clk after start for 20 clk ->
//      req_ready=0001 one cycle, tx_start pulse next clk, tx_data=0x41, grant_id=0.
//   2. All four valid continuously (bytes 0x30..0x33) -> tx_data order 0x30,0x31,
//      0x32,0x33,0x30; exactly one req_ready bit per frame.
//   3. After grant 2, only req 1 and 3 valid -> next grant 3, then 1.
//   4. tx_busy never asserted -> err pulse exactly ACK_TO clk after WAIT_BUSY entry,
//      back to IDLE, next grant proceeds normally.
//   5. Frame end (busy 1->0) with req valid -> no req_ready for GAP clk, accept at
//      GAP+1; with GAP=0 accept 1 clk after busy falls.
//   6. Assert rst=0 during WAIT_DONE -> all outputs at reset values immediately
//      (asynchronously); after release, req 0 granted first.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Shares one UART transmitter among NREQ byte producers. A round-robin
//   arbiter picks the next requester in IDLE, latches its byte, pulses
//   o_tx_start for one cycle, follows i_tx_busy through the frame and then
//   holds off for GAP idle cycles before the next grant. If the transmitter
//   never raises busy within ACK_TO cycles, o_err pulses and the byte is
//   dropped.
//
// Parameters
//   NREQ    number of requesters (2..8)
//   GAP     idle cycles after frame end before next grant (0 = none)
//   ACK_TO  cycles allowed for busy to rise after start (>=1)
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous reset, active-low
//   i_req_valid  [NREQ]    requester i has a byte pending
//   i_req_data   [NREQ*8]  byte of requester i at [8*i+7:8*i]
//   o_req_ready  [NREQ]    one-hot accept (transfer on valid & ready)
//   o_tx_data    [8]       byte presented to the transmitter
//   o_tx_start             one-cycle frame start pulse
//   i_tx_busy              transmitter frame in progress
//   o_grant_id   [clog2(NREQ)] index of requester currently served
//   o_active               high whenever not IDLE
//   o_err                  one-cycle pulse on ack timeout
module uart_tx_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned GAP    = 16,
  parameter int unsigned ACK_TO = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ*8-1:0]       i_req_data,
  output logic [NREQ-1:0]         o_req_ready,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_busy,
  output logic [$clog2(NREQ)-1:0] o_grant_id,
  output logic                    o_active,
  output logic                    o_err
);

  localparam int unsigned IW   = $clog2(NREQ);
  localparam int unsigned MAXC = (GAP > ACK_TO) ? GAP : ACK_TO;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_grant;
  logic [7:0]    r_tx_data;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic [IW-1:0] w_win;
  logic          w_any;
  logic          w_timeout;
  logic          w_gap_done;

  // Round-robin scan starting just after the last winner.
  always_comb begin : arb
    int unsigned idx;
    logic [IW-1:0] sel;
    w_any = 1'b0;
    w_win = '0;
    idx   = 0;
    sel   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(r_ptr) + k) % NREQ;
      sel = IW'(idx);
      if (!w_any && i_req_valid[sel]) begin
        w_any = 1'b1;
        w_win = sel;
      end
    end
  end

  assign w_timeout  = (r_state == S_WAIT_BUSY) && !i_tx_busy &&
                      (r_cnt == CW'(ACK_TO - 1));
  assign w_gap_done = (r_cnt == CW'(GAP - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_any) w_next = S_START;
      S_START:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (i_tx_busy)      w_next = S_WAIT_DONE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_WAIT_DONE: if (!i_tx_busy) w_next = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:       if (w_gap_done) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs; ready is also gated by reset so it reads zero while reset is held
  always_comb begin
    o_req_ready = '0;
    if ((r_state == S_IDLE) && i_rst_n && w_any)
      o_req_ready = NREQ'(1) << w_win;
    o_tx_start = (r_state == S_START);
    o_active   = (r_state != S_IDLE);
    o_tx_data  = r_tx_data;
    o_grant_id = r_grant;
    o_err      = r_err;
  end

  // Datapath: latched byte, pointer, shared timeout/gap counter, error pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr     <= IW'(NREQ - 1);
      r_grant   <= '0;
      r_tx_data <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_timeout;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_tx_data <= i_req_data[{w_win, 3'b000} +: 8];
            r_grant   <= w_win;
            r_ptr     <= w_win;
          end
        end
        S_START:     r_cnt <= '0;
        S_WAIT_BUSY: if (!i_tx_busy) r_cnt <= r_cnt + 1'b1;
        S_WAIT_DONE: r_cnt <= '0;
        S_GAP:       r_cnt <= r_cnt + 1'b1;
        default:     r_cnt <= '0;
      endcase
    end
  end

endmodule
